// File: rtl/keyed_seq_pkg.sv
// Shared types and decode helpers for the key-locked sequencing FSM.
// SEQ_KEY_SCRAMBLE_EN rotates the output code right by one while in a shadow state.
package keyed_seq_pkg;

    localparam int unsigned IDX_MAX_W  = 8;
    localparam int unsigned CODE_MAX_W = 256;

`ifdef SEQ_KEY_SCRAMBLE_EN
    localparam bit SCRAMBLE_ROT = 1'b1;
`else
    localparam bit SCRAMBLE_ROT = 1'b0;
`endif

    typedef enum logic {
        PLANE_REAL   = 1'b0,
        PLANE_SHADOW = 1'b1
    } plane_e;

    typedef struct packed {
        plane_e                 dup;
        logic [IDX_MAX_W-1:0]   idx;
    } seq_state_t;

    function automatic logic [IDX_MAX_W-1:0] next_idx(
        input logic [IDX_MAX_W-1:0] idx,
        input logic                 dir,
        input int unsigned          num_states
    );
        logic [IDX_MAX_W-1:0] last;
        last = IDX_MAX_W'(num_states - 1);
        if (dir) begin
            next_idx = (idx == '0) ? last : idx - IDX_MAX_W'(1);
        end else begin
            next_idx = (idx == last) ? '0 : idx + IDX_MAX_W'(1);
        end
    endfunction

    // One-hot code of idx; shadow states shift the hot bit down one place when scrambling.
    function automatic logic [CODE_MAX_W-1:0] out_code(
        input logic [IDX_MAX_W-1:0] idx,
        input logic                 dup,
        input int unsigned          out_w
    );
        logic [IDX_MAX_W-1:0] pos;
        pos = idx;
        if (dup && SCRAMBLE_ROT) begin
            pos = (idx == '0) ? IDX_MAX_W'(out_w - 1) : idx - IDX_MAX_W'(1);
        end
        out_code = CODE_MAX_W'(1) << pos;
    endfunction

endpackage

// File: rtl/lock_err_counter.sv
// Saturating shadow-dwell counter with threshold flag for keyed_seq_fsm.
module lock_err_counter #(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned THRESH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == THR) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign hit = (cnt == THR);

endmodule

// File: rtl/keyed_seq_fsm.sv
// Key-locked ring sequencer with shadow states, dwell counter and sticky trap lock.
// Optional SEQ_KEY_SCRAMBLE_EN: shadow states output the code rotated right by one.
import keyed_seq_pkg::*;

module keyed_seq_fsm #(
    parameter int unsigned      NUM_STATES  = 8,
    parameter int unsigned      OUT_W       = 8,
    parameter int unsigned      KEY_W       = 4,
    parameter logic [KEY_W-1:0] KEY_VALUE   = 4'b1010,
    parameter int unsigned      LOCK_THRESH = 5,
    parameter int unsigned      CNT_W       = 4,
    parameter int unsigned      TRAP_IDX    = 5,
    localparam int unsigned     IDX_W       = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             dir,
    input  logic [KEY_W-1:0] key,
    output logic [OUT_W-1:0] y,
    output logic [IDX_W-1:0] idx_o,
    output logic             dup_o,
    output logic             locked_o
);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             guarded;
    logic             key_ok;
    logic             locked;
    logic [CNT_W-1:0] err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '{dup: PLANE_REAL, idx: '0};
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        guarded = 1'b0;
        key_ok  = 1'b1;
        for (int k = 0; k < KEY_W; k++) begin
            if (state_q.idx == IDX_MAX_W'(k)) begin
                guarded = 1'b1;
                key_ok  = (key[k] == KEY_VALUE[k]);
            end
        end
        // Trap uses the pre-edge lock flag, so the locking edge still moves normally.
        if (adv) begin
            if (locked) begin
                state_d.idx = IDX_MAX_W'(TRAP_IDX);
                state_d.dup = PLANE_SHADOW;
            end else begin
                state_d.idx = next_idx(state_q.idx, dir, NUM_STATES);
                if (guarded) begin
                    state_d.dup = key_ok ? PLANE_REAL : PLANE_SHADOW;
                end
            end
        end
    end

    lock_err_counter #(
        .CNT_W  (CNT_W),
        .THRESH (LOCK_THRESH)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (state_q.dup == PLANE_SHADOW),
        .cnt (err_cnt),
        .hit (locked)
    );

    assign y        = OUT_W'(out_code(state_q.idx, state_q.dup == PLANE_SHADOW, OUT_W));
    assign idx_o    = state_q.idx[IDX_W-1:0];
    assign dup_o    = (state_q.dup == PLANE_SHADOW);
    assign locked_o = locked;

endmodule

// File: tb/tb_keyed_seq_fsm.sv
// Scoreboard bench for keyed_seq_fsm; honours SEQ_KEY_SCRAMBLE_EN for expected output codes.
module tb_keyed_seq_fsm;

    localparam int NUM_STATES  = 8;
    localparam int KEY_W       = 4;
    localparam int LOCK_THRESH = 5;
    localparam int TRAP        = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adv = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] key = 4'b0000;
    logic [7:0] y;
    logic [2:0] idx_o;
    logic       dup_o;
    logic       locked_o;

    typedef struct {
        logic [2:0] idx;
        logic       dup;
        logic [7:0] y;
        logic       locked;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_idx = 0;
    logic m_dup = 1'b0;
    int   m_cnt = 0;
    logic [3:0] kv = 4'b1010;

    keyed_seq_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .dir      (dir),
        .key      (key),
        .y        (y),
        .idx_o    (idx_o),
        .dup_o    (dup_o),
        .locked_o (locked_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [7:0] exp_y(input int idx, input logic dup);
        int pos;
        pos = idx;
`ifdef SEQ_KEY_SCRAMBLE_EN
        if (dup) pos = (idx + 7) % 8;
`endif
        return 8'(1 << pos);
    endfunction

    // Drive one cycle, advance the reference model, and queue the expected post-edge outputs.
    task automatic drive(input logic r, input logic a, input logic d, input logic [3:0] k);
        exp_t e;
        logic lk;
        int   n_cnt;
        @(negedge clk);
        rst = r; adv = a; dir = d; key = k;
        if (r) begin
            m_idx = 0; m_dup = 1'b0; m_cnt = 0;
        end else begin
            lk = (m_cnt == LOCK_THRESH);
            n_cnt = m_cnt;
            if (m_dup && m_cnt < LOCK_THRESH) n_cnt = m_cnt + 1;
            if (a) begin
                if (lk) begin
                    m_idx = TRAP; m_dup = 1'b1;
                end else begin
                    if (m_idx < KEY_W) m_dup = (k[m_idx] != kv[m_idx]);
                    m_idx = d ? (m_idx + NUM_STATES - 1) % NUM_STATES : (m_idx + 1) % NUM_STATES;
                end
            end
            m_cnt = n_cnt;
        end
        e.idx = 3'(m_idx); e.dup = m_dup; e.y = exp_y(m_idx, m_dup);
        e.locked = (m_cnt == LOCK_THRESH); e.cnt = 4'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        e = sb.pop_front();
        checks++;
        if ({idx_o, dup_o, y, locked_o, dut.u_err_cnt.cnt} !== {e.idx, e.dup, e.y, e.locked, e.cnt}) begin
            errors++;
            $display("FAIL reset_sb: got idx=%0d dup=%b y=%h lk=%b cnt=%0d want idx=%0d dup=%b y=%h lk=%b cnt=%0d",
                     idx_o, dup_o, y, locked_o, dut.u_err_cnt.cnt, e.idx, e.dup, e.y, e.locked, e.cnt);
        end
        checks++;
        if ({y, dup_o, locked_o} !== {8'h01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_lit: got y=%h dup=%b lk=%b want y=01 dup=0 lk=0", y, dup_o, locked_o);
        end
    endtask

    task automatic test_forward();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        void'(sb.pop_front());
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b1010);
            e = sb.pop_front();
            checks++;
            if ({idx_o, dup_o, y, locked_o} !== {e.idx, e.dup, e.y, e.locked}) begin
                errors++;
                $display("FAIL fwd_sb[%0d]: got idx=%0d dup=%b y=%h lk=%b want idx=%0d dup=%b y=%h lk=%b",
                         i, idx_o, dup_o, y, locked_o, e.idx, e.dup, e.y, e.locked);
            end
            checks++;
            if ({idx_o, y, dup_o} !== {3'((i + 1) % 8), 8'(1 << ((i + 1) % 8)), 1'b0}) begin
                errors++;
                $display("FAIL fwd_lit[%0d]: got idx=%0d y=%h dup=%b want idx=%0d", i, idx_o, y, dup_o, (i + 1) % 8);
            end
        end
    endtask

    task automatic test_wrong_key();
        logic [7:0] want_y;
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 1'b0, 4'b1011);
        void'(sb.pop_front());
`ifdef SEQ_KEY_SCRAMBLE_EN
        want_y = 8'h01;
`else
        want_y = 8'h02;
`endif
        checks++;
        if ({idx_o, dup_o, y} !== {3'd1, 1'b1, want_y}) begin
            errors++;
            $display("FAIL wrong_enter: got idx=%0d dup=%b y=%h want idx=1 dup=1 y=%h", idx_o, dup_o, y, want_y);
        end
        drive(1'b0, 1'b1, 1'b0, 4'b1010);
        void'(sb.pop_front());
        checks++;
        if ({idx_o, dup_o, locked_o, dut.u_err_cnt.cnt} !== {3'd2, 1'b0, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL wrong_leave: got idx=%0d dup=%b lk=%b cnt=%0d want idx=2 dup=0 lk=0 cnt=1",
                     idx_o, dup_o, locked_o, dut.u_err_cnt.cnt);
        end
    endtask

    task automatic test_lock();
        logic [7:0] want_y;
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 1'b0, 4'b1011);
        void'(sb.pop_front());
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'b0000);
            void'(sb.pop_front());
            checks++;
            if ({locked_o, dut.u_err_cnt.cnt, idx_o} !== {(i == 5), 4'(i), 3'd1}) begin
                errors++;
                $display("FAIL lock_dwell[%0d]: got lk=%b cnt=%0d idx=%0d want lk=%b cnt=%0d idx=1",
                         i, locked_o, dut.u_err_cnt.cnt, idx_o, (i == 5), i);
            end
        end
`ifdef SEQ_KEY_SCRAMBLE_EN
        want_y = 8'h10;
`else
        want_y = 8'h20;
`endif
        drive(1'b0, 1'b1, 1'b1, 4'b1010);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({idx_o, dup_o, y, locked_o} !== {3'd5, 1'b1, want_y, 1'b1}) begin
                errors++;
                $display("FAIL lock_trap[%0d]: got idx=%0d dup=%b y=%h lk=%b want idx=5 dup=1 y=%h lk=1",
                         i, idx_o, dup_o, y, locked_o, want_y);
            end
            drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            void'(sb.pop_front());
        end
    endtask

    task automatic test_backward();
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 1'b1, 4'b1010);
        void'(sb.pop_front());
        checks++;
        if ({idx_o, dup_o} !== {3'd7, 1'b0}) begin
            errors++;
            $display("FAIL back_ok: got idx=%0d dup=%b want idx=7 dup=0", idx_o, dup_o);
        end
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 1'b1, 4'b1011);
        void'(sb.pop_front());
        checks++;
        if ({idx_o, dup_o} !== {3'd7, 1'b1}) begin
            errors++;
            $display("FAIL back_bad: got idx=%0d dup=%b want idx=7 dup=1", idx_o, dup_o);
        end
    endtask

    task automatic test_unguarded();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b1010);
            void'(sb.pop_front());
        end
        drive(1'b0, 1'b1, 1'b0, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            e = sb.pop_front();
            checks++;
            if ({idx_o, dup_o, y, dut.u_err_cnt.cnt} !== {e.idx, e.dup, e.y, e.cnt}
                || idx_o !== 3'((4 + i) % 8) || dup_o !== 1'b1) begin
                errors++;
                $display("FAIL unguarded[%0d]: got idx=%0d dup=%b y=%h cnt=%0d want idx=%0d dup=1 y=%h cnt=%0d",
                         i, idx_o, dup_o, y, dut.u_err_cnt.cnt, (4 + i) % 8, e.y, e.cnt);
            end
            if (i < 4) drive(1'b0, 1'b1, 1'b0, {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))});
        end
        drive(1'b0, 1'b1, 1'b0, 4'b1010);
        e = sb.pop_front();
        checks++;
        if ({idx_o, dup_o, locked_o} !== {3'd1, 1'b0, 1'b1} || locked_o !== e.locked) begin
            errors++;
            $display("FAIL unguarded_exit: got idx=%0d dup=%b lk=%b want idx=1 dup=0 lk=1", idx_o, dup_o, locked_o);
        end
    endtask

    task automatic test_mid_reset();
        test_lock();
        drive(1'b1, 1'b1, 1'b1, 4'b0101);
        void'(sb.pop_front());
        checks++;
        if ({idx_o, y, dup_o, locked_o, dut.u_err_cnt.cnt} !== {3'd0, 8'h01, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL mid_reset: got idx=%0d y=%h dup=%b lk=%b cnt=%0d want idx=0 y=01 dup=0 lk=0 cnt=0",
                     idx_o, y, dup_o, locked_o, dut.u_err_cnt.cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            e = sb.pop_front();
            checks++;
            if ({idx_o, dup_o, y, locked_o, dut.u_err_cnt.cnt} !== {e.idx, e.dup, e.y, e.locked, e.cnt}) begin
                errors++;
                $display("FAIL b2b[%0d]: got idx=%0d dup=%b y=%h lk=%b cnt=%0d want idx=%0d dup=%b y=%h lk=%b cnt=%0d",
                         i, idx_o, dup_o, y, locked_o, dut.u_err_cnt.cnt, e.idx, e.dup, e.y, e.locked, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_wrong_key();
        test_lock();
        test_backward();
        test_unguarded();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
